button_array: RTL and testbench
===============================

// Module: button_array
// PURPOSE
//   Multi-channel debounced push-button front end: parametrised successor to the single-channel edge detector.
//   Per channel: 2-flop synchroniser, debounce filter, debounced level, one-cycle press/release pulses, long-press pulse.
//   Sits between the raw panel pins and the dispenser control FSM; the FSM consumes only the pulses and levels.
// PARAMETERS
//   CHANNELS          4   number of independent button channels (>=1)
//   DEBOUNCE_CYCLES   16  consecutive stable cycles to accept a new level (>=1)
//   LONG_PRESS_CYCLES 0   cycles held after press before long-press pulse; 0 = long-press disabled
//   ACTIVE_LOW        1   1: pin 0 = pressed (press = falling edge); 0: pin 1 = pressed
// PORTS
//   clock                input   1         single system clock, all logic on posedge
//   reset                input   1         asynchronous, active-low reset
//   button_value         input   CHANNELS  raw asynchronous button pins, bit i = channel i
//   pressed              output  CHANNELS  debounced level, 1 = held (polarity-normalised)
//   press_detected       output  CHANNELS  1-cycle pulse on accepted press
//   release_detected     output  CHANNELS  1-cycle pulse on accepted release
//   long_press_detected  output  CHANNELS  1-cycle pulse once per press when held LONG_PRESS_CYCLES
// BEHAVIOUR
//   Reset (reset=0, async): sync flops = released pin level (ACTIVE_LOW ? 1 : 0); debounced state released;
//     counters 0; pressed, press_detected, release_detected, long_press_detected all 0.
//   Reset release with pins at released level: no pulses ever generated from the reset itself.
//   Synchroniser: sync1 <= pin, sync2 <= sync1; normalised level s = ACTIVE_LOW ? ~sync2 : sync2.
//   Debounce counter per channel, width $clog2(DEBOUNCE_CYCLES+1):
//     s == pressed[i]: counter <= 0 (any glitch restarts the count).
//     s != pressed[i] and counter == DEBOUNCE_CYCLES-1: pressed[i] <= s, counter <= 0, pulse fires same edge.
//     otherwise counter <= counter+1.
//   Latency: clean pin change sampled at edge E0 -> pressed and pulse update at edge E0+DEBOUNCE_CYCLES+1;
//     i.e. pulse visible in the cycle after that edge, D+2 edges after the pin change.
//   press_detected[i]/release_detected[i]: registered, high exactly one cycle; never both high on a channel.
//   Long press (LONG_PRESS_CYCLES>0): hold counter cleared at press edge, +1 each cycle while pressed[i];
//     pulse when counter reaches LONG_PRESS_CYCLES, i.e. LONG_PRESS_CYCLES cycles after press_detected;
//     counter saturates (no wrap), fires once per press; cleared on release; release before threshold -> no pulse.
//   LONG_PRESS_CYCLES=0: long_press_detected tied 0, hold counter not synthesised.
//   Channels fully independent; simultaneous events on several channels give simultaneous pulses.
//   Reset mid-debounce or mid-hold: all state discarded immediately, no pulse on or after deassertion.
// TESTING (CHANNELS=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, ACTIVE_LOW=1)
//   Reset deasserted with pins=2'b11, run 50 cycles -> all outputs stay 0.
//   ch0 pin 1->0 clean before edge 0 -> press_detected=2'b01 for one cycle after edge 5; pressed[0]=1 from then.
//   ch0 pin low 3 cycles then high (bounce) -> no pulse, pressed[0] stays 0; repeat 5x -> still none.
//   ch0 held low 30 cycles -> long_press_detected[0] one cycle, exactly 10 cycles after press pulse, once only.
//   Both pins low same cycle, released after 5 cycles -> press pulses coincide, release pulses coincide, no long press.
//   reset asserted with ch1 counter=2 -> outputs 0 asynchronously; deassert with pins=2'b11 -> no pulses.

Source files
------------

// File: rtl/button_array.sv
// button_array: multi-channel synchronised, debounced push-button front end with
// one-cycle press/release pulses and an optional long-press pulse per channel.
module button_array #(
   parameter int CHANNELS          = 4,
   parameter int DEBOUNCE_CYCLES   = 16,
   parameter int LONG_PRESS_CYCLES = 0,
   parameter bit ACTIVE_LOW        = 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [CHANNELS-1:0] button_value,
   output logic [CHANNELS-1:0] pressed,
   output logic [CHANNELS-1:0] press_detected,
   output logic [CHANNELS-1:0] release_detected,
   output logic [CHANNELS-1:0] long_press_detected
);
   localparam int   CW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic IDLE = ACTIVE_LOW ? 1'b1 : 1'b0;
   logic [CHANNELS-1:0] sync1, sync2, level;
   assign level = ACTIVE_LOW ? ~sync2 : sync2;
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         sync1 <= {CHANNELS{IDLE}};
         sync2 <= {CHANNELS{IDLE}};
      end else begin
         sync1 <= button_value;
         sync2 <= sync1;
      end
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [CW-1:0] count;
      logic          held, press_q, release_q, accept;
      assign accept              = (level[i] != held) && (count == CW'(DEBOUNCE_CYCLES - 1));
      assign pressed[i]          = held;
      assign press_detected[i]   = press_q;
      assign release_detected[i] = release_q;
      // any sample matching the accepted level restarts the stability count
      always_ff @(posedge clock or negedge reset)
         if (!reset) begin
            count     <= '0;
            held      <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            count     <= (level[i] == held || accept) ? '0 : count + CW'(1);
            held      <= accept ? level[i] : held;
            press_q   <= accept & level[i];
            release_q <= accept & ~level[i];
         end
      if (LONG_PRESS_CYCLES > 0) begin : g_long
         localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
         logic [HW-1:0] hold;
         logic          long_q;
         assign long_press_detected[i] = long_q;
         // a release accepted on the threshold edge suppresses the long-press pulse
         always_ff @(posedge clock or negedge reset)
            if (!reset) begin
               hold   <= '0;
               long_q <= 1'b0;
            end else begin
               hold   <= (!held || accept) ? '0 : (hold == HW'(LONG_PRESS_CYCLES)) ? hold : hold + HW'(1);
               long_q <= held && !accept && (hold == HW'(LONG_PRESS_CYCLES - 1));
            end
      end else begin : g_no_long
         assign long_press_detected[i] = 1'b0;
      end
   end
endmodule

// File: tb/tb_button_array.sv
// tb_button_array: scoreboard bench; stimulus pushes expected pulse events with their
// cycle, a negedge monitor pops and compares every observed pulse.
module tb_button_array;
   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] button_value = 2'b11;
   logic [1:0] pressed, press_detected, release_detected, long_press_detected;
   int         cyc = 0, checks = 0, errors = 0;
   typedef struct {int cyc; logic [5:0] v;} ev_t;
   ev_t        sb[$];

   button_array #(
      .CHANNELS(2), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(10), .ACTIVE_LOW(1)
   ) dut (
      .clock(clock),
      .reset(reset),
      .button_value(button_value),
      .pressed(pressed),
      .press_detected(press_detected),
      .release_detected(release_detected),
      .long_press_detected(long_press_detected)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   // d = negedges from the drive point until the pulse is visible
   task automatic expect_ev(input int d, input logic [1:0] pd, input logic [1:0] rd, input logic [1:0] lp);
      ev_t e;
      e.cyc = cyc + d;
      e.v   = {pd, rd, lp};
      sb.push_back(e);
   endtask

   always @(negedge clock) begin
      ev_t        e;
      logic [5:0] obs;
      obs = {press_detected, release_detected, long_press_detected};
      if (obs != 6'b0) begin
         if (sb.size() == 0) check("spurious_pulse", 32'(obs), 32'd0);
         else begin
            e = sb.pop_front();
            check("pulse_cycle", cyc, e.cyc);
            check("pulse_value", 32'(obs), 32'(e.v));
         end
      end
   end

   initial begin
      #1;
      check("reset_pressed", 32'(pressed), 32'd0);
      check("reset_pulses", 32'({press_detected, release_detected, long_press_detected}), 32'd0);
      tick(2);
      reset = 1'b1;
      tick(50);
      check("idle_pressed", 32'(pressed), 32'd0);
      button_value = 2'b10;
      expect_ev(6, 2'b01, 2'b00, 2'b00);
      tick(5);
      check("press_not_early", 32'(pressed), 32'd0);
      tick(1);
      check("press_level", 32'(pressed), 32'b01);
      button_value = 2'b11;
      expect_ev(6, 2'b00, 2'b01, 2'b00);
      tick(6);
      check("release_level", 32'(pressed), 32'd0);
      for (int k = 0; k < 5; k++) begin
         button_value = 2'b10;
         tick(3);
         button_value = 2'b11;
         tick(3);
      end
      tick(10);
      check("bounce_level", 32'(pressed), 32'd0);
      button_value = 2'b10;
      expect_ev(6, 2'b01, 2'b00, 2'b00);
      expect_ev(16, 2'b00, 2'b00, 2'b01);
      tick(30);
      check("long_hold_level", 32'(pressed), 32'b01);
      button_value = 2'b11;
      expect_ev(6, 2'b00, 2'b01, 2'b00);
      tick(10);
      button_value = 2'b00;
      expect_ev(6, 2'b11, 2'b00, 2'b00);
      tick(5);
      button_value = 2'b11;
      expect_ev(6, 2'b00, 2'b11, 2'b00);
      tick(20);
      check("both_released", 32'(pressed), 32'd0);
      button_value = 2'b10;
      expect_ev(6, 2'b01, 2'b00, 2'b00);
      tick(7);
      check("pre_reset_level", 32'(pressed), 32'b01);
      button_value = 2'b00;
      tick(4);
      #2 reset = 1'b0;
      #1;
      check("async_reset_pressed", 32'(pressed), 32'd0);
      check("async_reset_pulses", 32'({press_detected, release_detected, long_press_detected}), 32'd0);
      button_value = 2'b11;
      tick(2);
      reset = 1'b1;
      tick(30);
      check("post_reset_pressed", 32'(pressed), 32'd0);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
